pwm_scheduler: RTL and testbench

Multi-channel PWM controller. Owns one shared prescaler and period counter, holds per-channel fill factors in double-buffered (shadow/active) registers, and drives NUM_CH PWM outputs.
- Fill-factor updates written by a host/sequencer over a valid/ready port take effect only at a period boundary, so no output glitches.
- Sits between the control FSM or bus interface and the PWM pins, replacing free-running per-channel counters.

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_sched_slot.sv | 76 +++++++
 rtl/pwm_scheduler.sv | 110 +++++++++++
 tb/tb_pwm_scheduler.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared widths, default output levels and the phase-stagger offset helper for pwm_scheduler.
package pwm_pkg;

  localparam logic ACT_STATE_DEF = 1'b1;
  localparam logic INACT_DEF     = ~ACT_STATE_DEF;

  function automatic int ff_w(input int fill_factor_max);
    return (fill_factor_max < 1) ? 1 : $clog2(fill_factor_max + 1);
  endfunction

  function automatic int ch_w(input int num_ch);
    return (num_ch <= 1) ? 1 : $clog2(num_ch);
  endfunction

  function automatic int presc_w(input int prescale);
    return (prescale <= 1) ? 1 : $clog2(prescale);
  endfunction

  // Channel i starts its period i*(MAX/NUM_CH) ticks out of phase with channel 0.
  function automatic int stagger_offset(input int idx, input int fill_factor_max, input int num_ch);
    return idx * (fill_factor_max / num_ch);
  endfunction

endpackage

// File: rtl/pwm_sched_slot.sv
// One PWM channel: shadow/active fill factor, pending-commit flag and registered compare output.
module pwm_sched_slot
  import pwm_pkg::*;
#(
  parameter int   FF_W            = 3,
  parameter int   FILL_FACTOR_MAX = 7,
  parameter int   OFFSET          = 0,
  parameter logic ACT_STATE       = ACT_STATE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            wr_en,
  input  logic [FF_W-1:0] wr_ff,
  input  logic            commit,
  input  logic [FF_W-1:0] cnt,
  input  logic            ch_en,
  output logic            q,
  output logic            upd_pend
);

  localparam logic [FF_W:0] OFFSET_W = (FF_W+1)'(OFFSET);
  localparam logic [FF_W:0] MAX_W    = (FF_W+1)'(FILL_FACTOR_MAX);

  logic [FF_W-1:0] shadow_q, shadow_d;
  logic [FF_W-1:0] active_q, active_d;
  logic            pend_q, pend_d;
  logic            q_q, q_d;
  logic [FF_W:0]   cnt_sum;
  logic [FF_W-1:0] cnt_i;

  // Offset is always < MAX, so a single conditional subtract is the modulo.
  assign cnt_sum = {1'b0, cnt} + OFFSET_W;
  assign cnt_i   = (cnt_sum >= MAX_W) ? FF_W'(cnt_sum - MAX_W) : cnt_sum[FF_W-1:0];

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    pend_d   = pend_q;
    if (wr_en) begin
      shadow_d = wr_ff;
      pend_d   = 1'b1;
    end else if (commit && pend_q) begin
      active_d = shadow_q;
      pend_d   = 1'b0;
    end
  end

  // Disable acts at once; otherwise the output only moves while the timebase runs.
  always_comb begin
    q_d = q_q;
    if (!ch_en) begin
      q_d = ~ACT_STATE;
    end else if (ce) begin
      q_d = (cnt_i < active_q) ? ACT_STATE : ~ACT_STATE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= '0;
      active_q <= '0;
      pend_q   <= 1'b0;
      q_q      <= ~ACT_STATE;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      pend_q   <= pend_d;
      q_q      <= q_d;
    end
  end

  assign q        = q_q;
  assign upd_pend = pend_q;

endmodule

// File: rtl/pwm_scheduler.sv
// Multi-channel PWM with shared prescaler/period counter and period-boundary fill-factor commit.
// Define PWM_PHASE_STAGGER_EN to phase-shift each channel's counter by i*(MAX/NUM_CH) ticks.
module pwm_scheduler
  import pwm_pkg::*;
#(
  parameter int   NUM_CH          = 4,
  parameter int   FILL_FACTOR_MAX = 7,
  parameter int   PRESCALE        = 1,
  parameter logic ACT_STATE       = ACT_STATE_DEF,
  localparam int  CH_W            = ch_w(NUM_CH),
  localparam int  FF_W            = ff_w(FILL_FACTOR_MAX)
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              CE,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [CH_W-1:0]   WR_CH,
  input  logic [FF_W-1:0]   WR_FF,
  input  logic [NUM_CH-1:0] CH_EN,
  output logic [NUM_CH-1:0] Q,
  output logic              PERIOD_END,
  output logic [NUM_CH-1:0] UPD_PEND,
  output logic              WR_ERR
);

  localparam int              PS_W     = presc_w(PRESCALE);
  localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
  localparam logic [FF_W-1:0] CNT_LAST = FF_W'(FILL_FACTOR_MAX - 1);
  localparam logic [FF_W:0]   FF_LIM   = (FF_W+1)'(FILL_FACTOR_MAX);

  logic [PS_W-1:0] presc_q, presc_d;
  logic [FF_W-1:0] cnt_q, cnt_d;
  logic            period_end_q, period_end_d;
  logic            wr_err_q, wr_err_d;
  logic            ready_q;
  logic            tick, wrap;
  logic            ch_ok, ff_ok, wr_fire, wr_accept;

  assign tick = CE & (presc_q == PS_LAST);
  assign wrap = tick & (cnt_q == CNT_LAST);

  // Holding off writes on the wrap cycle keeps shadow loads and commits mutually exclusive.
  assign WR_READY  = ready_q & ~wrap;
  assign wr_fire   = WR_VALID & WR_READY;
  assign ch_ok     = 32'(WR_CH) < 32'(NUM_CH);
  assign ff_ok     = {1'b0, WR_FF} <= FF_LIM;
  assign wr_accept = wr_fire & ch_ok & ff_ok;

  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    if (CE) begin
      presc_d = tick ? '0 : presc_q + PS_W'(1);
    end
    if (tick) begin
      cnt_d = wrap ? '0 : cnt_q + FF_W'(1);
    end
    period_end_d = wrap;
    wr_err_d     = wr_fire & ~(ch_ok & ff_ok);
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      presc_q      <= '0;
      cnt_q        <= '0;
      period_end_q <= 1'b0;
      wr_err_q     <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      period_end_q <= period_end_d;
      wr_err_q     <= wr_err_d;
      ready_q      <= 1'b1;
    end
  end

  assign PERIOD_END = period_end_q;
  assign WR_ERR     = wr_err_q;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_slot
`ifdef PWM_PHASE_STAGGER_EN
    localparam int OFFSET = stagger_offset(gi, FILL_FACTOR_MAX, NUM_CH);
`else
    localparam int OFFSET = 0;
`endif
    logic wr_en_ch;
    assign wr_en_ch = wr_accept & (WR_CH == CH_W'(gi));

    pwm_sched_slot #(
      .FF_W            (FF_W),
      .FILL_FACTOR_MAX (FILL_FACTOR_MAX),
      .OFFSET          (OFFSET),
      .ACT_STATE       (ACT_STATE)
    ) u_slot (
      .clk      (CLK),
      .rst_n    (CLR),
      .ce       (CE),
      .wr_en    (wr_en_ch),
      .wr_ff    (WR_FF),
      .commit   (wrap),
      .cnt      (cnt_q),
      .ch_en    (CH_EN[gi]),
      .q        (Q[gi]),
      .upd_pend (UPD_PEND[gi])
    );
  end

endmodule

// File: tb/tb_pwm_scheduler.sv
// Directed bench: default instance (4 ch, MAX 7, PRESCALE 1) plus a 3 ch / MAX 6 / PRESCALE 3 instance.
module tb_pwm_scheduler;

  logic       CLK;
  logic       clr, ce;
  logic       wr_valid, wr_ready, period_end, wr_err;
  logic [1:0] wr_ch;
  logic [2:0] wr_ff;
  logic [3:0] ch_en, q, upd_pend;

  logic       wr_valid_b, wr_ready_b, period_end_b, wr_err_b;
  logic [1:0] wr_ch_b;
  logic [2:0] wr_ff_b;
  logic [2:0] ch_en_b, q_b, upd_pend_b;

  int checks = 0;
  int failures = 0;
  int ff_a[4] = '{0, 0, 0, 0};

  pwm_scheduler dut_a (
    .CLK(CLK), .CLR(clr), .CE(ce), .WR_VALID(wr_valid), .WR_READY(wr_ready),
    .WR_CH(wr_ch), .WR_FF(wr_ff), .CH_EN(ch_en), .Q(q), .PERIOD_END(period_end),
    .UPD_PEND(upd_pend), .WR_ERR(wr_err)
  );

  pwm_scheduler #(.NUM_CH(3), .FILL_FACTOR_MAX(6), .PRESCALE(3), .ACT_STATE(1'b1)) dut_b (
    .CLK(CLK), .CLR(clr), .CE(ce), .WR_VALID(wr_valid_b), .WR_READY(wr_ready_b),
    .WR_CH(wr_ch_b), .WR_FF(wr_ff_b), .CH_EN(ch_en_b), .Q(q_b), .PERIOD_END(period_end_b),
    .UPD_PEND(upd_pend_b), .WR_ERR(wr_err_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Starts and ends just after a rising edge.
  task automatic wr_a(input int ch, input int ff);
    bit ok = 1'b0;
    wr_valid = 1'b1; wr_ch = 2'(ch); wr_ff = 3'(ff);
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge CLK);
      if (wr_ready) ok = 1'b1;
      @(posedge CLK); #1;
    end
    wr_valid = 1'b0;
    $display("write A ch=%0d ff=%0d accepted=%0b", ch, ff, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL wr_a_accept ch=%0d got_ready=0 required=1", ch); end
  endtask

  task automatic wr_b(input int ch, input int ff);
    bit ok = 1'b0;
    wr_valid_b = 1'b1; wr_ch_b = 2'(ch); wr_ff_b = 3'(ff);
    for (int n = 0; n < 20 && !ok; n++) begin
      @(negedge CLK);
      if (wr_ready_b) ok = 1'b1;
      @(posedge CLK); #1;
    end
    wr_valid_b = 1'b0;
    $display("write B ch=%0d ff=%0d accepted=%0b", ch, ff, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL wr_b_accept ch=%0d got_ready=0 required=1", ch); end
  endtask

  // Ends on the falling edge where PERIOD_END is seen high.
  task automatic wait_pe_a();
    bit ok = 1'b0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge CLK);
      if (period_end) ok = 1'b1;
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL wait_pe_a got=timeout required=PERIOD_END"); end
  endtask

  task automatic wait_pe_b();
    bit ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      @(negedge CLK);
      if (period_end_b) ok = 1'b1;
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL wait_pe_b got=timeout required=PERIOD_END"); end
  endtask

  function automatic logic [3:0] model_q(input int e, input logic [3:0] en);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = en[i] && (e < ff_a[i]);
    return r;
  endfunction

  task automatic test_reset();
    clr = 1'b0; ce = 1'b1; ch_en = 4'hF; ch_en_b = 3'b111;
    wr_valid = 1'b0; wr_ch = '0; wr_ff = '0;
    wr_valid_b = 1'b0; wr_ch_b = '0; wr_ff_b = '0;
    repeat (2) @(negedge CLK);
    checks++;
    if ({q, upd_pend, period_end, wr_err, wr_ready} !== 11'b0) begin
      failures++;
      $display("FAIL reset_a got=%b required=0", {q, upd_pend, period_end, wr_err, wr_ready});
    end
    checks++;
    if ({q_b, upd_pend_b, period_end_b, wr_err_b, wr_ready_b} !== 9'b0) begin
      failures++;
      $display("FAIL reset_b got=%b required=0", {q_b, upd_pend_b, period_end_b, wr_err_b, wr_ready_b});
    end
    @(posedge CLK); #1; clr = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (wr_ready !== 1'b1) begin failures++; $display("FAIL ready_after_reset got=%b required=1", wr_ready); end
  endtask

  task automatic test_basic();
    logic [3:0] exp_q;
    @(posedge CLK); #1;
    wr_a(0, 3);
    @(negedge CLK);
    checks++;
    if (upd_pend !== 4'b0001) begin failures++; $display("FAIL basic_pend got=%b required=0001", upd_pend); end
    wait_pe_a();
    checks++;
    if (upd_pend !== 4'b0000) begin failures++; $display("FAIL basic_commit got=%b required=0000", upd_pend); end
    ff_a[0] = 3;
    for (int k = 1; k <= 14; k++) begin
      @(negedge CLK);
      exp_q = model_q((k - 1) % 7, 4'hF);
      checks++;
      if (q !== exp_q || period_end !== (k % 7 == 0)) begin
        failures++;
        $display("FAIL basic_k%0d got q=%b pe=%b required q=%b pe=%b", k, q, period_end, exp_q, (k % 7 == 0));
      end
    end
  endtask

  task automatic test_bounds();
    logic [3:0] exp_q;
    wait_pe_a();
    @(posedge CLK); #1;
    wr_a(1, 0);
    wr_a(2, 7);
    wr_a(3, 2);
    wr_a(3, 5);
    @(negedge CLK);
    checks++;
    if (upd_pend !== 4'b1110) begin failures++; $display("FAIL bounds_pend got=%b required=1110", upd_pend); end
    wait_pe_a();
    checks++;
    if (upd_pend !== 4'b0000) begin failures++; $display("FAIL bounds_commit got=%b required=0000", upd_pend); end
    ff_a[1] = 0; ff_a[2] = 7; ff_a[3] = 5;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      exp_q = model_q(k - 1, 4'hF);
      checks++;
      if (q !== exp_q) begin failures++; $display("FAIL bounds_k%0d got q=%b required q=%b", k, q, exp_q); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_q;
    wait_pe_a();
    repeat (6) @(posedge CLK);
    #1; wr_valid = 1'b1; wr_ch = 2'd1; wr_ff = 3'd4;
    @(negedge CLK);
    checks++;
    if (wr_ready !== 1'b0) begin failures++; $display("FAIL stall_ready_on_wrap got=%b required=0", wr_ready); end
    @(negedge CLK);
    checks++;
    if (period_end !== 1'b1 || wr_ready !== 1'b1 || upd_pend !== 4'b0000) begin
      failures++;
      $display("FAIL stall_after_wrap got pe=%b ready=%b pend=%b required pe=1 ready=1 pend=0000", period_end, wr_ready, upd_pend);
    end
    @(posedge CLK); #1; wr_valid = 1'b0;
    @(negedge CLK);
    checks++;
    if (upd_pend !== 4'b0010) begin failures++; $display("FAIL stall_pend got=%b required=0010", upd_pend); end
    wait_pe_a();
    checks++;
    if (upd_pend !== 4'b0000) begin failures++; $display("FAIL stall_commit got=%b required=0000", upd_pend); end
    ff_a[1] = 4;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CLK);
      exp_q = model_q(k - 1, 4'hF);
      checks++;
      if (q !== exp_q) begin failures++; $display("FAIL stall_k%0d got q=%b required q=%b", k, q, exp_q); end
    end
  endtask

  task automatic test_ce_and_enable();
    logic [3:0] exp_q;
    int e;
    wait_pe_a();
    for (int k = 1; k <= 12; k++) begin
      @(negedge CLK);
      e = (k <= 3) ? k - 1 : (k <= 8) ? 2 : k - 6;
      exp_q = model_q(e, 4'hF);
      checks++;
      if (q !== exp_q || period_end !== (k == 12)) begin
        failures++;
        $display("FAIL ce_k%0d got q=%b pe=%b required q=%b pe=%b", k, q, period_end, exp_q, (k == 12));
      end
      if (k == 5) begin
        checks++;
        if (wr_ready !== 1'b1) begin failures++; $display("FAIL ce_ready got=%b required=1", wr_ready); end
      end
      if (k == 3) ce = 1'b0;
      if (k == 8) ce = 1'b1;
    end
    @(posedge CLK); #1; ch_en = 4'hE;
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      exp_q = model_q(k - 1, (k == 2) ? 4'hE : 4'hF);
      checks++;
      if (q !== exp_q) begin failures++; $display("FAIL ch_en_k%0d got q=%b required q=%b", k, q, exp_q); end
      if (k == 2) ch_en = 4'hF;
    end
  endtask

  task automatic test_prescale_invalid();
    logic [2:0] exp_q;
    wait_pe_b();
    @(posedge CLK); #1;
    wr_b(0, 3);
    @(negedge CLK);
    checks++;
    if (wr_err_b !== 1'b0 || upd_pend_b !== 3'b001) begin
      failures++;
      $display("FAIL valid_b got err=%b pend=%b required err=0 pend=001", wr_err_b, upd_pend_b);
    end
    @(posedge CLK); #1;
    wr_b(0, 7);
    @(negedge CLK);
    checks++;
    if (wr_err_b !== 1'b1) begin failures++; $display("FAIL err_ff got=%b required=1", wr_err_b); end
    @(posedge CLK); #1;
    wr_b(3, 1);
    @(negedge CLK);
    checks++;
    if (wr_err_b !== 1'b1 || upd_pend_b !== 3'b001) begin
      failures++;
      $display("FAIL err_ch got err=%b pend=%b required err=1 pend=001", wr_err_b, upd_pend_b);
    end
    @(negedge CLK);
    checks++;
    if (wr_err_b !== 1'b0) begin failures++; $display("FAIL err_pulse_width got=%b required=0", wr_err_b); end
    wait_pe_b();
    checks++;
    if (upd_pend_b !== 3'b000) begin failures++; $display("FAIL commit_b got=%b required=000", upd_pend_b); end
    for (int k = 1; k <= 18; k++) begin
      @(negedge CLK);
      exp_q = {2'b00, (k - 1) < 9};
      checks++;
      if (q_b !== exp_q || period_end_b !== (k == 18)) begin
        failures++;
        $display("FAIL presc_k%0d got q=%b pe=%b required q=%b pe=%b", k, q_b, period_end_b, exp_q, (k == 18));
      end
    end
  endtask

  task automatic test_async_clear();
    @(posedge CLK); #1;
    wr_a(1, 6);
    #2; clr = 1'b0;
    #1;
    checks++;
    if ({q, upd_pend, period_end, wr_err, wr_ready} !== 11'b0) begin
      failures++;
      $display("FAIL async_clr got=%b required=0", {q, upd_pend, period_end, wr_err, wr_ready});
    end
    @(posedge CLK); #1; clr = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    checks++;
    if (q !== 4'b0000 || wr_ready !== 1'b1) begin
      failures++;
      $display("FAIL after_clr got q=%b ready=%b required q=0000 ready=1", q, wr_ready);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bounds();
    test_back_to_back();
    test_ce_and_enable();
    test_prescale_invalid();
    test_async_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
